// File: rtl/crc32_stream_pkg.sv
// Shared CRC-32 constants, frame-tracking state type and bit-reflection helpers
// for the crc32_stream engine and its byte-step sub-module.
package crc32_stream_pkg;

  localparam int unsigned CRC_LEN     = 32;
  localparam logic [CRC_LEN-1:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [CRC_LEN-1:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [CRC_LEN-1:0] CRC_XOR_OUT = 32'hFFFFFFFF;
  localparam logic [CRC_LEN-1:0] CRC_RESIDUE = 32'h2144DF1C;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } crc_state_t;

  // Bit-reverse one byte.
  function automatic logic [7:0] reflect8(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction

  // Bit-reverse a 32-bit word.
  function automatic logic [31:0] reflect32(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction

endpackage

// File: rtl/crc32_stream_byte_step.sv
// One byte of MSB-first CRC-32 update; bytes are reflected so the result matches
// the LSB-first wire order of Ethernet.
// Ports:
//   i_acc   accumulator before this byte
//   i_byte  byte as seen on the wire
//   i_en    0 = pass accumulator through unchanged
//   o_acc   accumulator after this byte
module crc32_byte_step
  import crc32_stream_pkg::*;
#(
  parameter logic [31:0] POLY = CRC_POLY
) (
  input  logic [31:0] i_acc,
  input  logic [7:0]  i_byte,
  input  logic        i_en,
  output logic [31:0] o_acc
);

  logic [31:0] w_acc;

  // XOR reflected byte into the top, then 8 MSB-first shift/reduce steps.
  always_comb begin
    w_acc = i_acc ^ {reflect8(i_byte), 24'h0};
    for (int i = 0; i < 8; i++) begin
      w_acc = w_acc[31] ? ((w_acc << 1) ^ POLY) : (w_acc << 1);
    end
    o_acc = i_en ? w_acc : i_acc;
  end

endmodule

// File: rtl/crc32_stream.sv
// Streaming Ethernet CRC-32 (FCS) engine: DATA_BYTES bytes per beat over valid/ready,
// per-lane keep on the last beat, registered valid/ready result port.
// Optional feature macro: CRC_FCS_CHECK_EN -- when defined, fcs_ok flags a frame
// (fed including its received FCS) whose CRC equals the CRC-32 residue.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   in_valid/ready  input beat handshake
//   in_data         beat data, lane 0 = [7:0] = first byte on the wire
//   in_keep         byte enables, honoured on the last beat only
//   in_last         final beat of frame
//   crc_valid/ready result handshake
//   crc_out         FCS, lane-0-first byte order
//   byte_cnt        bytes in the completed frame (saturating)
//   fcs_ok          RX residue check result (0 when feature absent)
module crc32_stream
  import crc32_stream_pkg::*;
#(
  parameter int unsigned DATA_BYTES = 4,
  parameter logic [31:0] POLY       = CRC_POLY,
  parameter logic [31:0] INIT       = CRC_INIT,
  parameter logic [31:0] XOR_OUT    = CRC_XOR_OUT,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [8*DATA_BYTES-1:0] in_data,
  input  logic [DATA_BYTES-1:0]   in_keep,
  input  logic                    in_last,
  output logic                    crc_valid,
  input  logic                    crc_ready,
  output logic [31:0]             crc_out,
  output logic [CNT_W-1:0]        byte_cnt,
  output logic                    fcs_ok
);

  localparam int unsigned POP_W = $clog2(DATA_BYTES + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  crc_state_t       r_state;
  logic [31:0]      r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_up;
  logic             r_crc_valid;
  logic [31:0]      r_crc_out;
  logic [CNT_W-1:0] r_byte_cnt;

  logic                  w_ready;
  logic                  w_accept;
  logic [DATA_BYTES-1:0] w_lane_en;
  logic [31:0]           w_seed;
  logic [31:0]           w_chain [DATA_BYTES+1];
  logic [31:0]           w_crc_final;
  logic [POP_W-1:0]      w_pop;
  logic [CNT_W-1:0]      w_cnt_base;
  logic [SUM_W-1:0]      w_cnt_sum;
  logic [CNT_W-1:0]      w_cnt_next;

  // r_up holds in_ready low for the cycle following reset.
  assign w_ready  = r_up && ((r_state != DONE) || crc_ready);
  assign w_accept = in_valid && w_ready;
  assign in_ready = w_ready;

  // keep only matters on the last beat; earlier beats are always full.
  assign w_lane_en = in_last ? in_keep : {DATA_BYTES{1'b1}};

  // A beat outside ACCUM always opens a fresh frame.
  assign w_seed     = (r_state == ACCUM) ? r_acc : INIT;
  assign w_cnt_base = (r_state == ACCUM) ? r_cnt : '0;

  assign w_chain[0] = w_seed;

  // Lane chain: lane 0 first, matching wire order.
  for (genvar g = 0; g < DATA_BYTES; g++) begin : g_lane
    crc32_byte_step #(.POLY(POLY)) u_step (
      .i_acc  (w_chain[g]),
      .i_byte (in_data[8*g +: 8]),
      .i_en   (w_lane_en[g]),
      .o_acc  (w_chain[g+1])
    );
  end

  assign w_crc_final = reflect32(w_chain[DATA_BYTES]) ^ XOR_OUT;

  // Byte count of this beat, added to the running count with saturation.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < DATA_BYTES; i++) w_pop = w_pop + POP_W'(w_lane_en[i]);
    w_cnt_sum  = {1'b0, w_cnt_base} + SUM_W'(w_pop);
    w_cnt_next = w_cnt_sum[CNT_W] ? {CNT_W{1'b1}} : w_cnt_sum[CNT_W-1:0];
  end

  // Frame FSM, accumulator and registered result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_acc       <= INIT;
      r_cnt       <= '0;
      r_up        <= 1'b0;
      r_crc_valid <= 1'b0;
      r_crc_out   <= '0;
      r_byte_cnt  <= '0;
    end else begin
      r_up <= 1'b1;
      if (w_accept) begin
        r_acc <= w_chain[DATA_BYTES];
        r_cnt <= w_cnt_next;
        if (in_last) begin
          r_state     <= DONE;
          r_crc_valid <= 1'b1;
          r_crc_out   <= w_crc_final;
          r_byte_cnt  <= w_cnt_next;
        end else begin
          // Also covers DONE: accepting implies the old result was taken.
          r_state     <= ACCUM;
          r_crc_valid <= 1'b0;
        end
      end else if ((r_state == DONE) && crc_ready) begin
        r_state     <= IDLE;
        r_crc_valid <= 1'b0;
      end
    end
  end

  assign crc_valid = r_crc_valid;
  assign crc_out   = r_crc_out;
  assign byte_cnt  = r_byte_cnt;

`ifdef CRC_FCS_CHECK_EN
  logic r_fcs_ok;

  // Residue compare, loaded alongside the result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fcs_ok <= 1'b0;
    end else if (w_accept && in_last) begin
      r_fcs_ok <= (w_crc_final == CRC_RESIDUE);
    end
  end

  assign fcs_ok = r_fcs_ok;
`else
  assign fcs_ok = 1'b0;
`endif

endmodule

// File: tb/tb_crc32_stream.sv
module tb_crc32_stream;

  typedef logic [7:0] bq_t [$];

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // 4-byte-lane instance
  logic        v4 = 1'b0, l4 = 1'b0, cr4 = 1'b1;
  logic [31:0] d4 = '0;
  logic [3:0]  k4 = '0;
  logic        r4, cv4, fo4;
  logic [31:0] co4;
  logic [15:0] bc4;

  // 1-byte-lane instance
  logic        v1 = 1'b0, l1 = 1'b0, cr1 = 1'b1;
  logic [7:0]  d1 = '0;
  logic [0:0]  k1 = 1'b1;
  logic        r1, cv1, fo1;
  logic [31:0] co1;
  logic [15:0] bc1;

  int n_vec = 0;
  int n_err = 0;

  crc32_stream #(.DATA_BYTES(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(r4), .in_data(d4), .in_keep(k4),
    .in_last(l4), .crc_valid(cv4), .crc_ready(cr4), .crc_out(co4), .byte_cnt(bc4),
    .fcs_ok(fo4));

  crc32_stream #(.DATA_BYTES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_data(d1), .in_keep(k1),
    .in_last(l1), .crc_valid(cv1), .crc_ready(cr1), .crc_out(co1), .byte_cnt(bc1),
    .fcs_ok(fo1));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference CRC-32: reflected LSB-first algorithm.
  function automatic logic [31:0] crc_ref(input bq_t b);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic logic fcs_exp(input logic [31:0] c);
`ifdef CRC_FCS_CHECK_EN
    return c == 32'h2144DF1C;
`else
    return (c != c);
`endif
  endfunction

  // Frame-level model of the 4-lane instance.
  logic        started = 1'b0;
  logic        m_up = 1'b0, m_valid = 1'b0, m_fcs = 1'b0;
  logic [31:0] m_crc = '0;
  logic [15:0] m_cnt = '0;
  bq_t         cur;

  initial begin
    logic rdy;
    forever begin
      @(posedge clk);
      started = 1'b1;
      if (!rst) begin
        m_up = 1'b0;
        m_valid = 1'b0;
        cur.delete();
      end else begin
        rdy = m_up && (!m_valid || cr4);
        if (m_valid && cr4) m_valid = 1'b0;
        if (v4 && rdy) begin
          for (int j = 0; j < 4; j++) if (!l4 || k4[j]) cur.push_back(d4[8*j +: 8]);
          if (l4) begin
            m_crc   = crc_ref(cur);
            m_cnt   = (cur.size() > 65535) ? 16'hFFFF : 16'(cur.size());
            m_fcs   = fcs_exp(m_crc);
            m_valid = 1'b1;
            cur.delete();
          end
        end
        m_up = 1'b1;
      end
    end
  end

  // Cycle-by-cycle compare of the 4-lane instance.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        check("in_ready", 32'(r4), 32'(m_up && (!m_valid || cr4)));
        check("crc_valid", 32'(cv4), 32'(m_valid));
        if (m_valid) begin
          check("crc_out", co4, m_crc);
          check("byte_cnt", 32'(bc4), 32'(m_cnt));
          check("fcs_ok", 32'(fo4), 32'(m_fcs));
        end
      end
    end
  end

  task automatic send_beat(input logic [31:0] data, input logic [3:0] keep, input logic last);
    logic got = 1'b0;
    v4 = 1'b1; d4 = data; k4 = keep; l4 = last;
    for (int t = 0; t < 64 && !got; t++) begin
      @(negedge clk);
      got = r4;
      @(posedge clk);
      #1;
    end
    check("beat_accept", 32'(got), 32'd1);
  endtask

  task automatic send_bytes(input bq_t b, input logic empty_last);
    int n = b.size();
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    for (int i = 0; i < n; i += 4) begin
      data = 32'hA5A5A5A5;
      keep = '0;
      for (int j = 0; j < 4; j++) if (i + j < n) begin
        data[8*j +: 8] = b[i+j];
        keep[j] = 1'b1;
      end
      last = (i + 4 >= n) && !empty_last;
      send_beat(data, last ? keep : 4'hF, last);
    end
    if (empty_last) send_beat(32'h5A5A5A5A, 4'h0, 1'b1);
  endtask

  task automatic idle(input int n);
    v4 = 1'b0; l4 = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic reset_checks();
    check("rst_in_ready", 32'(r4), 32'd0);
    check("rst_crc_valid", 32'(cv4), 32'd0);
    check("rst_crc_out", co4, 32'd0);
    check("rst_byte_cnt", 32'(bc4), 32'd0);
    check("rst_fcs_ok", 32'(fo4), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t q, q9, q8, qf;
    string s9;
    s9 = "123456789";
    q9 = str2q(s9);
    q8 = str2q("12345678");
    qf = q9;
    qf.push_back(8'h26); qf.push_back(8'h39); qf.push_back(8'hF4); qf.push_back(8'hCB);

    // Pin the reference model with known values.
    check("model_check_9", crc_ref(q9), 32'hCBF43926);
    check("model_check_8", crc_ref(q8), 32'h9AE0DAAF);
    check("model_residue", crc_ref(qf), 32'h2144DF1C);

    // Reset state.
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_checks();
    check("rst1_crc_valid", 32'(cv1), 32'd0);
    check("rst1_crc_out", co1, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle(2);

    // 1-byte lanes: "123456789", result one cycle after last.
    for (int i = 0; i < 9; i++) begin
      v1 = 1'b1; d1 = s9[i]; l1 = (i == 8);
      @(negedge clk);
      check("d1_in_ready", 32'(r1), 32'd1);
      check("d1_no_early_valid", 32'(cv1), 32'd0);
      @(posedge clk); #1;
    end
    v1 = 1'b0; l1 = 1'b0;
    @(negedge clk);
    check("d1_crc_valid", 32'(cv1), 32'd1);
    check("d1_crc_out", co1, 32'hCBF43926);
    check("d1_byte_cnt", 32'(bc1), 32'd9);
    check("d1_fcs_ok", 32'(fo1), 32'(fcs_exp(32'hCBF43926)));
    @(negedge clk);
    check("d1_valid_drop", 32'(cv1), 32'd0);

    // 4-byte lanes: "1234","5678","9" keep 0001.
    send_bytes(q9, 1'b0);
    idle(3);

    // Back-to-back frames, consumer always ready.
    send_bytes(q9, 1'b0);
    send_bytes(q9, 1'b0);
    idle(3);

    // Consumer stall: result held, new frame blocked for 3+ cycles.
    cr4 = 1'b0;
    send_bytes(q9, 1'b0);
    fork
      begin repeat (4) @(posedge clk); #1 cr4 = 1'b1; end
      send_bytes(str2q("hello"), 1'b0);
    join
    idle(3);

    // Reset mid-frame: partial frame discarded.
    send_beat({8'h34, 8'h33, 8'h32, 8'h31}, 4'hF, 1'b0);
    v4 = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    reset_checks();
    @(posedge clk); #1;
    rst = 1'b1;
    idle(1);
    send_bytes(q9, 1'b0);
    idle(3);

    // Frame including its FCS, then with one bit flipped.
    send_bytes(qf, 1'b0);
    idle(2);
    q = qf;
    q[3] = q[3] ^ 8'h10;
    send_bytes(q, 1'b0);
    idle(2);

    // Empty last beat after "12345678".
    send_bytes(q8, 1'b1);
    idle(2);

    // Partial last beats with keep 0011 and 0111.
    send_bytes(str2q("abcdef"), 1'b0);
    send_bytes(str2q("ABCDEFG"), 1'b0);
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/crc32_stream.md
Name: crc32_stream

Overview:
- Parametrised successor to the single-byte Ethernet CRC32 engine.
- Accepts DATA_BYTES bytes per beat over a valid/ready stream, with per-lane keep on the final beat, and tracks frame boundaries with a small state machine.
- Presents the finished FCS through a registered valid/ready result port.
- Sits in the MAC TX path (FCS generation) and the RX path (FCS check, optional feature).

Parameters:
- DATA_BYTES, 4, bytes per beat; legal values 1, 2, 4, 8.
- POLY, global::crc_poly (32'h04C11DB7), generator polynomial, normal (MSB-first) form.
- INIT, 32'hFFFFFFFF, accumulator value at start of each frame.
- XOR_OUT, 32'hFFFFFFFF, final XOR applied to the reflected accumulator.
- CNT_W, 16, width of the frame byte counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  8*DATA_BYTES  beat data; lane 0 = bits [7:0] = first byte on wire.
- in_keep  in  DATA_BYTES  byte enables; sampled on last beat only.
- in_last  in  1  final beat of frame.
- crc_valid  out  1  crc_out/byte_cnt hold a completed frame result.
- crc_ready  in  1  consumer accepts the result.
- crc_out  out  32  FCS = reflect32(acc) ^ XOR_OUT; lane-0-first byte order as transmitted.
- byte_cnt  out  CNT_W  bytes in the completed frame.
- fcs_ok  out  1  RX check result (see Optional Feature).

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, acc=INIT, in_ready=0, crc_valid=0, crc_out=0, byte_cnt=0, fcs_ok=0. Reset mid-frame discards the partial frame; no result is emitted.
- in_ready=1 in IDLE and ACCUM. In DONE: in_ready = crc_ready, so a new frame can start in the cycle the result is taken.
- A beat is accepted when in_valid && in_ready.
- Per-beat update:
  - Lanes are processed 0..DATA_BYTES-1 in order.
  - Each byte is bit-reflected, XORed into acc[31:24], then shifted MSB-first for 8 steps.
  - Lanes with keep==0 leave acc unchanged.
  - On non-last beats all lanes count as valid.
- in_keep must be contiguous from lane 0 (e.g. 4'b0111). A non-contiguous keep is undefined.
- keep all-zero on a last beat contributes no bytes.
- State machine:
  - IDLE: on accept, the update is seeded from INIT. in_last=1 -> DONE; else -> ACCUM.
  - ACCUM: on accept, update. in_last=1 -> DONE.
  - DONE: crc_valid=1. crc_valid && crc_ready -> IDLE, or -> ACCUM/DONE if a new beat is accepted in the same cycle (back-to-back frames).
- Latency: crc_valid rises the cycle after the last beat is accepted. Results are registered and stable while crc_valid && !crc_ready.
- byte_cnt: sum of popcount(keep) per beat (DATA_BYTES on non-last beats). Saturates at all-ones; no wrap. Resets to 0 at the start of each frame.
- Throughput: one beat per cycle; no bubbles between frames when crc_ready=1.

Optional Feature:
- Macro: CRC_FCS_CHECK_EN.
- Defined: the frame is fed including its 4 received FCS bytes. fcs_ok is registered with crc_valid and equals (crc_out == 32'h2144DF1C), the CRC-32 residue.
- Undefined: fcs_ok is tied 0 and the compare logic is absent.
- crc_out behaviour is identical in both builds.

Decomposition:
- Package global holds:
  - crc_len (32), crc_poly, CRC_INIT, CRC_XOR_OUT, CRC_RESIDUE (32'h2144DF1C);
  - crc_state_t enum {IDLE, ACCUM, DONE};
  - reflect8/reflect32 functions.
- One sub-module: crc32_byte_step. Combinational, acc_in[31:0] + byte + en -> acc_out. It is instantiated DATA_BYTES times as a chain.

Test Plan:
- DATA_BYTES=1, ASCII "123456789" one byte per beat, last on '9' -> crc_out=32'hCBF43926, byte_cnt=9, crc_valid one cycle after last.
- DATA_BYTES=4, beats "1234", "5678", "9" with keep=4'b0001 -> crc_out=32'hCBF43926, byte_cnt=9.
- Back-to-back: two 9-byte frames, crc_ready=1 always -> two results, no in_ready deassertion, both 32'hCBF43926. Hold crc_ready=0 for 3 cycles -> in_ready=0, result stable until taken.
- Reset mid-frame: drive rst=0 after beat "1234", release, send full "123456789" -> single result 32'hCBF43926; no spurious crc_valid.
- CRC_FCS_CHECK_EN: "123456789" followed by bytes 26 39 F4 CB -> fcs_ok=1. Flip one data bit -> fcs_ok=0.
- Last beat with keep=0 after "12345678" (DATA_BYTES=4) -> byte_cnt=8, crc_out equals CRC of "12345678" (32'h9AE0DAAF).
